// File: rtl/rf_pkg.sv
// Shared types for the register-file write path.
// Write request bundle and architectural register constants.
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wr_req_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO of write requests for long-latency results.
// Pointers wrap modulo DEPTH; count tells full from empty.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  wr_req_t       din_i,
  input  logic          pop_i,
  output wr_req_t       dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  wr_req_t       mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care when not counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din_i;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the RF write port: writeback first, long-latency FIFO fills gaps.
// Optional RF_WB_BYPASS_EN drives an lu result straight to the port.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              wb_stall,
  output logic              we3,
  output logic [REG_AW-1:0] a3,
  output logic [XLEN-1:0]   wd3,
  output logic [NUM_REGS-1:0] pend_mask
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wr_req_t       head, wr_d;
  logic          full, empty;
  logic [CW-1:0] fifo_cnt;
  logic          wb_win, lu_fire, push, pop, byp, we_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q;
  logic          we3_q;
  wr_req_t       wr_q;
  logic [CW-1:0] pcnt_q [NUM_REGS];
  logic [CW-1:0] pcnt_d [NUM_REGS];

  assign lu_ready = resetn && !full;
  assign lu_fire  = lu_valid && lu_ready;
  assign wb_win   = wb_valid && (wb_rd != ZERO_REG);

`ifdef RF_WB_BYPASS_EN
  assign byp = lu_fire && (lu_rd != ZERO_REG) && empty && !wb_win;
`else
  assign byp = 1'b0;
`endif

  assign push = lu_fire && (lu_rd != ZERO_REG) && !byp;
  assign pop  = !wb_win && !empty;

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .din_i   ('{rd: lu_rd, data: lu_data}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  // Pick this cycle's winner for the write port.
  always_comb begin
    we_d = 1'b0;
    wr_d = '0;
    unique case (1'b1)
      wb_win: begin
        we_d = 1'b1;
        wr_d = '{rd: wb_rd, data: wb_data};
      end
      pop: begin
        we_d = 1'b1;
        wr_d = head;
      end
      byp: begin
        we_d = 1'b1;
        wr_d = '{rd: lu_rd, data: lu_data};
      end
      default: ;
    endcase
  end

  // Count writeback wins that block a waiting FIFO head.
  always_comb begin
    starve_d = starve_q;
    if (fifo_cnt == '0 || pop)
      starve_d = '0;
    else if (wb_win && starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  // Per-register queued-write counts.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pcnt_d[r] = pcnt_q[r]
        + CW'(push && lu_rd == REG_AW'(r))
        - CW'(pop && head.rd == REG_AW'(r));
    end
  end

  // Pending mask decoded from counts; x0 is never pending.
  always_comb begin
    pend_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pend_mask[r] = (pcnt_q[r] != '0);
    end
  end

  // Registered write port, stall and bookkeeping state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      we3_q    <= 1'b0;
      wr_q     <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) pcnt_q[r] <= '0;
    end else begin
      we3_q    <= we_d;
      wr_q     <= wr_d;
      starve_q <= starve_d;
      stall_q  <= (starve_d == SW'(STARVE_MAX));
      for (int r = 0; r < NUM_REGS; r++) pcnt_q[r] <= pcnt_d[r];
    end
  end

  assign we3      = we3_q;
  assign a3       = wr_q.rd;
  assign wd3      = wr_q.data;
  assign wb_stall = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter.
// Expected writes are queued; a monitor checks each we3 pulse in order.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        wb_stall;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pend_mask;

  int pass_cnt = 0;
  int total_cnt = 0;
  wr_req_t exp_q[$];

  rf_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .wb_stall  (wb_stall),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, want);
  endtask

  task automatic expw(input logic [4:0] rd, input logic [31:0] d);
    wr_req_t e;
    e.rd = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write pulse must match the next expected write.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: a3=%0d wd3=%h", a3, wd3);
      end else begin
        wr_req_t e;
        e = exp_q.pop_front();
        if (a3 === e.rd && wd3 === e.data) pass_cnt++;
        else $display("FAIL write_order: got rd=%0d data=%h want rd=%0d data=%h",
                      a3, wd3, e.rd, e.data);
      end
    end
  end

  initial begin
    resetn = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
    tick(); tick();
    chk("rst_we3", 32'(we3), 0);
    chk("rst_lu_ready", 32'(lu_ready), 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_stall", 32'(wb_stall), 0);
    resetn = 1'b1; lu_valid = 1'b0;
    #1 chk("post_rst_ready", 32'(lu_ready), 1);
    tick();
    chk("post_rst_we3", 32'(we3), 0);

    // Writeback only.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    expw(5'd5, 32'hDEADBEEF);
    tick();
    chk("wb_we3", 32'(we3), 1);
    chk("wb_a3", 32'(a3), 5);
    chk("wb_wd3", wd3, 32'hDEADBEEF);
    wb_valid = 1'b0;
    tick();
    chk("wb_one_cycle", 32'(we3), 0);

    // x0 writes from both sources are dropped.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h2;
    #1 chk("x0_lu_ready", 32'(lu_ready), 1);
    tick();
    chk("x0_we3", 32'(we3), 0);
    chk("x0_pend", pend_mask, 0);
    wb_valid = 1'b0; lu_valid = 1'b0;
    tick();
    chk("x0_we3_late", 32'(we3), 0);
    chk("x0_pend_late", pend_mask, 0);

    // Fill FIFO while writeback is busy.
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1'b1; wb_rd = 5'(16 + k); wb_data = 32'(32'hA0 + k);
      lu_valid = 1'b1; lu_rd = 5'(k + 1); lu_data = 32'(17 * (k + 1));
      expw(5'(16 + k), 32'(32'hA0 + k));
      tick();
    end
    lu_rd = 5'd6; lu_data = 32'h66;
    chk("full_lu_ready", 32'(lu_ready), 0);
    chk("full_pend", pend_mask, 32'h1E);
    chk("full_stall", 32'(wb_stall), 0);

    // Drain in arrival order once writeback idles.
    wb_valid = 1'b0; lu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expw(5'(k + 1), 32'(17 * (k + 1)));
      tick();
      chk("drain_we3", 32'(we3), 1);
      chk("drain_a3", 32'(a3), 32'(k + 1));
    end
    chk("drain_pend", pend_mask, 0);
    chk("drain_lu_ready", 32'(lu_ready), 1);
    tick();
    chk("drain_idle", 32'(we3), 0);

    // Starvation: rd=7 queued behind continuous writeback.
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'h200;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h77;
    expw(5'd20, 32'h200);
    tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wb_rd = 5'd21; wb_data = 32'(32'h300 + i);
      expw(5'd21, 32'(32'h300 + i));
      tick();
      chk("starve_stall", 32'(wb_stall), (i == 7) ? 1 : 0);
    end
    chk("starve_pend7", 32'(pend_mask[7]), 1);
    wb_valid = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h78;
    expw(5'd7, 32'h77);
    tick();
    chk("starve_we3", 32'(we3), 1);
    chk("starve_a3", 32'(a3), 7);
    chk("starve_stall_clr", 32'(wb_stall), 0);
    chk("pushpop_pend7", 32'(pend_mask[7]), 1);
    lu_valid = 1'b0;
    expw(5'd7, 32'h78);
    tick();
    chk("second7_wd3", wd3, 32'h78);
    tick();
    chk("starve_pend_end", pend_mask, 0);
    chk("starve_idle", 32'(we3), 0);

    // Direct lu result with empty FIFO and idle writeback.
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    expw(5'd9, 32'h99);
    tick();
    lu_valid = 1'b0;
`ifdef RF_WB_BYPASS_EN
    chk("byp_we3_n1", 32'(we3), 1);
    chk("byp_a3_n1", 32'(a3), 9);
    chk("byp_pend9", 32'(pend_mask[9]), 0);
    tick();
    chk("byp_we3_n2", 32'(we3), 0);
    chk("byp_pend9_n2", 32'(pend_mask[9]), 0);
`else
    chk("lat_we3_n1", 32'(we3), 0);
    chk("lat_pend9", 32'(pend_mask[9]), 1);
    tick();
    chk("lat_we3_n2", 32'(we3), 1);
    chk("lat_a3_n2", 32'(a3), 9);
`endif
    tick(); tick();
    chk("pend_final", pend_mask, 0);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
